// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, hiding MEM_LATENCY behind req/done.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_done,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_done,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic                    take_d, take_f;

  // owner_q = 1 means the load/store unit owns the access; in RESP only the other port may be granted
  always_comb begin
    take_d     = d_req && (state_q == IDLE || (state_q == RESP && !owner_q));
    take_f     = if_req && ((state_q == IDLE && !d_req) || (state_q == RESP && owner_q));
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (take_d) begin
      state_d = BUSY;
      owner_d = 1'b1;
      we_d    = d_we;
      addr_d  = d_addr;
      wdata_d = d_wdata;
      wstrb_d = d_wstrb;
      cnt_d   = CNT_INIT;
    end else if (take_f) begin
      state_d = BUSY;
      owner_d = 1'b0;
      we_d    = 1'b0;
      addr_d  = if_addr;
      wdata_d = '0;
      wstrb_d = '0;
      cnt_d   = CNT_INIT;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        state_d    = RESP;
        cnt_d      = cnt_q;
        if_rdata_d = owner_q ? if_rdata_q : mem_rdata;
        d_rdata_d  = (owner_q && !we_q) ? mem_rdata : d_rdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign busy      = state_q != IDLE;
  assign mem_en    = state_q == BUSY;
  assign mem_we    = mem_en && we_q;
  assign mem_wstrb = mem_en ? wstrb_q : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = state_q == RESP && !owner_q;
  assign d_done    = state_q == RESP && owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a per-access timeline model checked every cycle.
module tb_mem_port_arbiter;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int we_cnt = 0;
  int if_done_n = 0;
  int d_done_n = 0;

  logic [31:0] mem [0:63];

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk)
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  // Model: age = cycles since grant (-1 idle); memory active for ages 0..L-1, done at age L.
  int          age = -1;
  logic        m_own = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, e_if = '0, e_d = '0;
  logic [3:0]  m_wstrb = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      age  <= -1;
      e_if <= '0;
      e_d  <= '0;
    end else if (age == -1 || age == L) begin
      if ((age == -1 && d_req) || (age == L && !m_own && d_req)) begin
        age <= 0; m_own <= 1'b1; m_we <= d_we; m_addr <= d_addr; m_wdata <= d_wdata; m_wstrb <= d_wstrb;
      end else if ((age == -1 && if_req) || (age == L && m_own && if_req)) begin
        age <= 0; m_own <= 1'b0; m_we <= 1'b0; m_addr <= if_addr; m_wstrb <= '0;
      end else begin
        age <= -1;
      end
    end else begin
      if (age == L - 1) begin
        if (!m_own) e_if <= mem[m_addr[7:2]];
        else if (!m_we) e_d <= mem[m_addr[7:2]];
      end
      age <= age + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic en;
    en = age >= 0 && age < L;
    chk("busy", 32'(busy), 32'(age >= 0));
    chk("mem_en", 32'(mem_en), 32'(en));
    chk("mem_we", 32'(mem_we), 32'(en && m_we));
    chk("mem_wstrb", 32'(mem_wstrb), en ? 32'(m_wstrb) : 32'd0);
    if (en) chk("mem_addr", mem_addr, m_addr);
    if (en && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_done", 32'(if_done), 32'(age == L && !m_own));
    chk("d_done", 32'(d_done), 32'(age == L && m_own));
    chk("if_rdata", if_rdata, e_if);
    chk("d_rdata", d_rdata, e_d);
    if (mem_en) en_cnt++;
    if (mem_we) we_cnt++;
    if (if_done) if_done_n++;
    if (d_done) d_done_n++;
  end

  task automatic do_fetch(input logic [31:0] a, output int dc);
    if_addr = a;
    if_req = 1'b1;
    dc = -1;
    for (int n = 0; n < 50 && dc < 0; n++) begin
      @(negedge clk);
      if (if_done) dc = cyc;
    end
    checks++;
    if (dc < 0) begin errors++; $display("FAIL fetch_timeout: no if_done within 50 cycles, required one"); end
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output int dc);
    d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
    d_req = 1'b1;
    dc = -1;
    for (int n = 0; n < 50 && dc < 0; n++) begin
      @(negedge clk);
      if (d_done) dc = cyc;
    end
    checks++;
    if (dc < 0) begin errors++; $display("FAIL data_timeout: no d_done within 50 cycles, required one"); end
    d_req = 1'b0;
  endtask

  initial begin
    int s, c1, c2, n0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[4] = 32'h00500F93;
    mem[5] = 32'h12345678;

    // reset held low with a fetch request pending
    if_req = 1'b1; if_addr = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_en_seen", 32'(en_cnt), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_done", 32'(d_done), 32'd0);
    if_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single fetch
    en_cnt = 0; s = cyc;
    do_fetch(32'h10, c1);
    chk("fetch_latency", 32'(c1 - s), 32'(L + 1));
    chk("fetch_en_cycles", 32'(en_cnt), 32'(L));
    chk("fetch_data", if_rdata, 32'h00500F93);
    @(negedge clk);
    chk("fetch_then_idle", 32'(busy), 32'd0);

    // store then load
    en_cnt = 0; we_cnt = 0;
    do_data(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, c1);
    chk("store_we_cycles", 32'(we_cnt), 32'(L));
    chk("store_drdata_kept", d_rdata, 32'd0);
    @(negedge clk);
    chk("store_mem", mem[16], 32'hDEADBEEF);
    do_data(1'b0, 32'h40, 32'h0, 4'h0, c1);
    chk("load_data", d_rdata, 32'hDEADBEEF);

    // partial store: only byte 1 updated
    @(negedge clk);
    do_data(1'b1, 32'h44, 32'hAABBCCDD, 4'b0010, c1);
    @(negedge clk);
    chk("store_strb", mem[17], 32'h1000CC11);

    // contention: data wins, fetch follows straight from RESP
    @(negedge clk);
    fork
      do_fetch(32'h14, c2);
      do_data(1'b0, 32'h40, 32'h0, 4'h0, c1);
    join
    chk("contend_gap", 32'(c2 - c1), 32'(L + 1));
    chk("contend_if_data", if_rdata, 32'h12345678);
    chk("contend_d_data", d_rdata, 32'hDEADBEEF);

    // fetch held past done: no service from RESP, repeat only via IDLE
    @(negedge clk);
    if_addr = 32'h10; if_req = 1'b1;
    c1 = -1;
    for (int n = 0; n < 50 && c1 < 0; n++) begin @(negedge clk); if (if_done) c1 = cyc; end
    @(negedge clk);
    chk("late_no_access", 32'(mem_en), 32'd0);
    chk("late_idle", 32'(busy), 32'd0);
    c2 = -1;
    for (int n = 0; n < 50 && c2 < 0; n++) begin @(negedge clk); if (if_done) c2 = cyc; end
    if_req = 1'b0;
    chk("repeat_gap", 32'(c2 - c1), 32'(L + 2));

    // reset during BUSY
    @(negedge clk);
    if_addr = 32'h14; if_req = 1'b1;
    for (int n = 0; n < 10 && !mem_en; n++) @(negedge clk);
    chk("mid_busy_en", 32'(mem_en), 32'd1);
    n0 = if_done_n;
    #2 reset = 1'b0;
    #1 chk("async_mem_en", 32'(mem_en), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abandon_no_done", 32'(if_done_n - n0), 32'd0);
    chk("abandon_idle", 32'(busy), 32'd0);
    chk("abandon_rdata_cleared", if_rdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
